parameterized_shift_register: RTL and testbench
===============================================

PARAMETERIZED_SHIFT_REGISTER -- requirements
Module: parameterized_shift_register

Interface
REQ-001 Parameter: w, 4, register width in bits; SHALL support any w >= 2.
REQ-002 Parameter: shift_direction, "left", string; "right" selects right shift, any other value SHALL select left shift.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 aclr  input  1  active-high clear, sampled synchronously on clk, highest priority.
REQ-006 sclr  input  1  synchronous active-high clear.
REQ-007 aset  input  1  active-high set-all-ones, sampled synchronously on clk.
REQ-008 sset  input  1  synchronous active-high set-all-ones.
REQ-009 load  input  1  parallel-load request, qualified by en.
REQ-010 en  input  1  enable for load and shift.
REQ-011 SI  input  1  serial data in.
REQ-012 data  input  w  parallel load value.
REQ-013 SO  output  1  serial data out, combinational from q.
REQ-014 q  output  w  register contents, driven directly from the state register.
REQ-015 Positional port order SHALL be: sclr, sset, load, en, aclr, aset, clk, SI, SO, data, q.

Function
REQ-016 On each rising clk edge, q SHALL update per the first true condition: aclr -> all zeros; aset -> all ones; sclr -> all zeros; sset -> all ones; en&load -> data; en -> shift; otherwise hold.
REQ-017 sclr, sset, aclr and aset SHALL act regardless of en and load.
REQ-018 Left shift: q_next = {q[w-2:0], SI}; SO = q[w-1].
REQ-019 Right shift: q_next = {SI, q[w-1:1]}; SO = q[0].
REQ-020 SO SHALL always reflect the current q bit selected by REQ-018/REQ-019, with no extra register stage.
REQ-021 load with en=0 SHALL be ignored (q holds).
REQ-022 Latency: every operation SHALL be visible on q and SO one clk edge after the controls are sampled; no multi-cycle state.
REQ-023 Simultaneous controls SHALL resolve strictly by REQ-016 priority (e.g. aclr=aset=1 -> zeros; aset=1 with load=en=1 -> ones).
REQ-024 X/Z on data or SI SHALL only propagate on load or shift; clear/set results SHALL be independent of data and SI.

Reset
REQ-025 Reset conditions are aclr or sclr, both synchronous active-high; on the next rising clk edge q SHALL be all zeros and SO SHALL be 0.
REQ-026 A reset asserted mid-shift or mid-load SHALL override that operation on the same edge; after deassertion, operation resumes from zeros.
REQ-027 Before the first reset/set/load, q SHALL be undefined; no power-on initialization is required.

Verification (w=4, left, data=1101)
REQ-028 sset=1, en=0, other controls 0, one edge -> q=1111, SO=1; then sclr=1, one edge -> q=0000, SO=0.
REQ-029 aset=1 one edge -> q=1111; then aclr=1 one edge -> q=0000; aclr=aset=1 together -> q=0000.
REQ-030 aset=1, load=1, en=1 -> q=1111 (set beats load); then aclr=1 -> q=0000.
REQ-031 load=1, en=1 -> q=1101, SO=1; then load=0, en=1, SI=0 -> q=1010, SO=1; then SI=1 -> q=0101, SO=0.
REQ-032 From q=1101: en=0, load=1, all others 0, several edges -> q holds 1101.
REQ-033 shift_direction="right", from q=1101: en=1, SI=1 -> q=1110, SO=0; then SI=0 -> q=0111, SO=1.

Source files
------------

// File: rtl/parameterized_shift_register.sv
// Parameterized serial/parallel shift register.
// Controls are all sampled on the rising clock edge with fixed priority:
// aclr, aset, sclr, sset, load (when enabled), shift (when enabled), hold.
// Shift direction is chosen at elaboration time; SO taps the bit that
// leaves the register on the next shift.
module parameterized_shift_register #(
  parameter int    w               = 4,
  parameter string shift_direction = "left"
) (
  input  logic         sclr,
  input  logic         sset,
  input  logic         load,
  input  logic         en,
  input  logic         aclr,
  input  logic         aset,
  input  logic         clk,
  input  logic         SI,
  output logic         SO,
  input  logic [w-1:0] data,
  output logic [w-1:0] q
);

  // Only the exact string "right" selects right shift; anything else is left.
  localparam bit right_shift = (shift_direction == "right");

  logic [w-1:0] q_r;
  logic [w-1:0] shifted_s;
  logic [w-1:0] q_next_s;
  logic         so_s;

  // Shifted value of the current contents with SI entering at the open end.
  always_comb begin
    shifted_s = q_r;
    if (right_shift) begin
      shifted_s = {SI, q_r[w-1:1]};
    end else begin
      shifted_s = {q_r[w-2:0], SI};
    end
  end

  // Next-state selection below the highest-priority clear; set/clear values
  // never depend on data or SI so unknowns there cannot leak into them.
  always_comb begin
    q_next_s = q_r;
    if (aset) begin
      q_next_s = {w{1'b1}};
    end else if (sclr) begin
      q_next_s = {w{1'b0}};
    end else if (sset) begin
      q_next_s = {w{1'b1}};
    end else if (en && load) begin
      q_next_s = data;
    end else if (en) begin
      q_next_s = shifted_s;
    end else begin
      q_next_s = q_r;
    end
  end

  // State register; aclr is the synchronous clear that overrides everything.
  always_ff @(posedge clk) begin
    if (aclr) begin
      q_r <= {w{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  // Serial out is the outgoing bit of the current contents, no extra stage.
  always_comb begin
    so_s = 1'b0;
    if (right_shift) begin
      so_s = q_r[0];
    end else begin
      so_s = q_r[w-1];
    end
  end

  assign q  = q_r;
  assign SO = so_s;

endmodule

// File: tb/tb_parameterized_shift_register.sv
// Scoreboard bench: a left-shifting and a right-shifting instance (w=4) see
// the same controls; expected contents are queued at drive time and popped
// one edge later when the outputs are sampled.
module tb_parameterized_shift_register;

  logic       clk = 1'b0;
  logic       sclr, sset, load, en, aclr, aset, si;
  logic [3:0] data;
  logic       so_l, so_r;
  logic [3:0] q_l, q_r;

  typedef struct packed {
    logic [3:0] ql;
    logic       sol;
    logic [3:0] qr;
    logic       sor;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_l, m_r;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  parameterized_shift_register #(.w(4), .shift_direction("left")) dut_l (
    .sclr(sclr), .sset(sset), .load(load), .en(en), .aclr(aclr), .aset(aset),
    .clk(clk), .SI(si), .SO(so_l), .data(data), .q(q_l)
  );

  parameterized_shift_register #(.w(4), .shift_direction("right")) dut_r (
    .sclr(sclr), .sset(sset), .load(load), .en(en), .aclr(aclr), .aset(aset),
    .clk(clk), .SI(si), .SO(so_r), .data(data), .q(q_r)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference behaviour written from the priority list.
  function automatic logic [3:0] ref_next(input logic [3:0] cur, input bit right);
    if (aclr)             return 4'b0000;
    else if (aset)        return 4'b1111;
    else if (sclr)        return 4'b0000;
    else if (sset)        return 4'b1111;
    else if (en && load)  return data;
    else if (en)          return right ? {si, cur[3:1]} : {cur[2:0], si};
    else                  return cur;
  endfunction

  // Drive one set of controls, queue expectation, clock, then pop and compare.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [3:0] d, input logic s);
    exp_t e, got;
    {aclr, aset, sclr, sset, load, en} = ctl;
    data = d;
    si   = s;
    m_l  = ref_next(m_l, 1'b0);
    m_r  = ref_next(m_r, 1'b1);
    e.ql = m_l; e.sol = m_l[3]; e.qr = m_r; e.sor = m_r[0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      got.ql = q_l; got.sol = so_l; got.qr = q_r; got.sor = so_r;
      check_eq({tag, "_ql"},  {4'b0, got.ql},  {4'b0, e.ql});
      check_eq({tag, "_sol"}, {7'b0, got.sol}, {7'b0, e.sol});
      check_eq({tag, "_qr"},  {4'b0, got.qr},  {4'b0, e.qr});
      check_eq({tag, "_sor"}, {7'b0, got.sor}, {7'b0, e.sor});
    end
  endtask

  // control vector order: {aclr, aset, sclr, sset, load, en}
  initial begin
    logic [5:0] ctl;
    {aclr, aset, sclr, sset, load, en, si} = 7'b0;
    data = 4'b0000;
    m_l  = 4'bxxxx;
    m_r  = 4'bxxxx;
    @(posedge clk);
    #1;

    step("sset",        6'b000100, 4'b1101, 1'b0);
    check_eq("lit_sset", {4'b0, q_l}, 8'b0000_1111);
    step("sclr",        6'b001000, 4'b1101, 1'b1);
    check_eq("lit_sclr", {4'b0, q_l}, 8'b0000_0000);
    step("aset",        6'b010000, 4'b1101, 1'b0);
    step("aclr",        6'b100000, 4'b1101, 1'b1);
    step("aclr_aset",   6'b110000, 4'b1101, 1'b1);
    check_eq("lit_aclr_aset", {4'b0, q_l}, 8'b0000_0000);
    step("aset_load",   6'b010011, 4'b1101, 1'b0);
    check_eq("lit_aset_load", {4'b0, q_l}, 8'b0000_1111);
    step("aclr2",       6'b100011, 4'b1101, 1'b1);
    step("load",        6'b000011, 4'b1101, 1'b0);
    check_eq("lit_load", {4'b0, q_l}, 8'b0000_1101);
    step("shift_si0",   6'b000001, 4'b1101, 1'b0);
    check_eq("lit_shl0", {4'b0, q_l}, 8'b0000_1010);
    step("shift_si1",   6'b000001, 4'b1101, 1'b1);
    check_eq("lit_shl1", {3'b0, so_l, q_l}, 8'b0000_0101);
    step("reload",      6'b000011, 4'b1101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("load_no_en", 6'b000010, 4'b0010, 1'b1);
    end
    check_eq("lit_hold", {4'b0, q_l}, 8'b0000_1101);
    step("rshift_si1",  6'b000001, 4'b0000, 1'b1);
    check_eq("lit_shr1", {3'b0, so_r, q_r}, 8'b0000_1110);
    step("rshift_si0",  6'b000001, 4'b0000, 1'b0);
    check_eq("lit_shr0", {3'b0, so_r, q_r}, 8'b0001_0111);
    step("clr_midload", 6'b001011, 4'b1111, 1'b1);
    step("set_midshift", 6'b000101, 4'b0000, 1'b0);
    step("x_data_clr",  6'b001011, 4'bxxxx, 1'bx);
    step("x_data_set",  6'b010001, 4'bxxxx, 1'bx);

    for (int i = 0; i < 60; i++) begin
      ctl[5] = ($urandom_range(0, 15) == 0);
      ctl[4] = ($urandom_range(0, 15) == 0);
      ctl[3] = ($urandom_range(0, 15) == 0);
      ctl[2] = ($urandom_range(0, 15) == 0);
      ctl[1] = ($urandom_range(0, 3) == 0);
      ctl[0] = ($urandom_range(0, 3) != 0);
      step("rand", ctl, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    check_eq("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
